// File: rtl/sort_net_pipe_if.sv
// sort_net_pipe_if: stream bundle for the sort_net_pipe core.
//   in_valid / in_ready / in_desc / in_data  : input vector handshake
//   out_valid / out_ready / out_data         : sorted vector handshake
//   out_min / out_max / out_med              : order statistics of out_data
//   out_idx                                  : original index per output element
//                                              (only with SORT_NET_IDX_EN)
// Modports: master = the environment (source + sink), slave = the core.
// Build option: define SORT_NET_IDX_EN to carry index tags.
interface sort_net_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int IDXW = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_desc;
    logic [N*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [WIDTH-1:0]     out_min;
    logic [WIDTH-1:0]     out_max;
    logic [WIDTH-1:0]     out_med;
`ifdef SORT_NET_IDX_EN
    logic [N*IDXW-1:0]    out_idx;

    modport master (
        output in_valid, in_desc, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_min, out_max, out_med, out_idx
    );
    modport slave (
        input  in_valid, in_desc, in_data, out_ready,
        output in_ready, out_valid, out_data, out_min, out_max, out_med, out_idx
    );
`else
    modport master (
        output in_valid, in_desc, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_min, out_max, out_med
    );
    modport slave (
        input  in_valid, in_desc, in_data, out_ready,
        output in_ready, out_valid, out_data, out_min, out_max, out_med
    );
`endif
endinterface

// File: rtl/sort_net_pipe.sv
// sort_net_pipe: fully pipelined odd-even transposition sorting network for
// N unsigned WIDTH-bit elements, ascending or descending per vector.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (clears control and data registers)
//   bus  - sort_net_pipe_if.slave: input vector handshake, sorted output
//          vector handshake plus min / max / lower median (and out_idx)
// Build option: SORT_NET_IDX_EN adds per-element index tags and out_idx.
// Pipeline: register 0 captures the accepted vector unsorted, registers
// 1..N each hold the result of one compare-swap stage, so a vector accepted
// at edge t is on the outputs after edge t+N.
module sort_net_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           rst,
    sort_net_pipe_if.slave bus
);
    localparam int IDXW = $clog2(N);
    localparam int MED  = (N - 1) / 2;

    logic [WIDTH-1:0] dat_p   [N+1][N];
    logic             desc_p  [N+1];
    logic             vld_p   [N+1];
    logic [WIDTH-1:0] nxt_dat [N+1][N];
    logic             nxt_desc[N+1];
    logic             nxt_vld [N+1];
`ifdef SORT_NET_IDX_EN
    logic [IDXW-1:0]  idx_p   [N+1][N];
    logic [IDXW-1:0]  nxt_idx [N+1][N];
`endif
    logic             stall;

    // Strict comparison keeps equal values in place, which makes the sort stable.
    function automatic logic do_swap(input logic [WIDTH-1:0] lo,
                                     input logic [WIDTH-1:0] hi,
                                     input logic             desc);
        return desc ? (lo < hi) : (lo > hi);
    endfunction

    assign stall        = vld_p[N] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        // capture stage: raw vector, tags start as original positions
        for (int i = 0; i < N; i++) begin
            nxt_dat[0][i] = bus.in_data[i*WIDTH +: WIDTH];
`ifdef SORT_NET_IDX_EN
            nxt_idx[0][i] = IDXW'(i);
`endif
        end
        nxt_desc[0] = bus.in_desc;
        nxt_vld[0]  = bus.in_valid;

        // compare-swap stage s feeds register s+1; even s pairs (0,1),(2,3)..,
        // odd s pairs (1,2),(3,4)..; unpaired edge elements pass through
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < N; i++) begin
                nxt_dat[s+1][i] = dat_p[s][i];
`ifdef SORT_NET_IDX_EN
                nxt_idx[s+1][i] = idx_p[s][i];
`endif
            end
            nxt_desc[s+1] = desc_p[s];
            nxt_vld[s+1]  = vld_p[s];
            for (int i = s % 2; i + 1 < N; i += 2) begin
                if (do_swap(dat_p[s][i], dat_p[s][i+1], desc_p[s])) begin
                    nxt_dat[s+1][i]   = dat_p[s][i+1];
                    nxt_dat[s+1][i+1] = dat_p[s][i];
`ifdef SORT_NET_IDX_EN
                    nxt_idx[s+1][i]   = idx_p[s][i+1];
                    nxt_idx[s+1][i+1] = idx_p[s][i];
`endif
                end
            end
        end
    end

    // whole pipeline advances together or holds together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s <= N; s++) begin
                for (int i = 0; i < N; i++) begin
                    dat_p[s][i] <= '0;
`ifdef SORT_NET_IDX_EN
                    idx_p[s][i] <= '0;
`endif
                end
                desc_p[s] <= 1'b0;
                vld_p[s]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int s = 0; s <= N; s++) begin
                for (int i = 0; i < N; i++) begin
                    dat_p[s][i] <= nxt_dat[s][i];
`ifdef SORT_NET_IDX_EN
                    idx_p[s][i] <= nxt_idx[s][i];
`endif
                end
                desc_p[s] <= nxt_desc[s];
                vld_p[s]  <= nxt_vld[s];
            end
        end
    end

    // outputs: final register only; mode picks which end holds min and max
    always_comb begin
        bus.out_data = '0;
`ifdef SORT_NET_IDX_EN
        bus.out_idx  = '0;
`endif
        for (int i = 0; i < N; i++) begin
            bus.out_data[i*WIDTH +: WIDTH] = dat_p[N][i];
`ifdef SORT_NET_IDX_EN
            bus.out_idx[i*IDXW +: IDXW]    = idx_p[N][i];
`endif
        end
        bus.out_valid = vld_p[N];
        bus.out_min   = desc_p[N] ? dat_p[N][N-1]     : dat_p[N][0];
        bus.out_max   = desc_p[N] ? dat_p[N][0]       : dat_p[N][N-1];
        bus.out_med   = desc_p[N] ? dat_p[N][N-1-MED] : dat_p[N][MED];
    end
endmodule

// File: tb/tb_sort_net_pipe.sv
// tb_sort_net_pipe: self-checking bench for sort_net_pipe (N=4, WIDTH=8).
// A monitor keeps a scoreboard of expected results (pushed on acceptance,
// popped on output transfer); scenario tasks add their own timing checks.
module tb_sort_net_pipe;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sort_net_pipe_if #(.WIDTH(W), .N(N)) bus();
    sort_net_pipe #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [N*W-1:0]  data;
        logic [W-1:0]    mn;
        logic [W-1:0]    mx;
        logic [W-1:0]    md;
        logic [N*IW-1:0] idx;
    } exp_t;

    typedef struct packed {
        logic [N*W-1:0]  vin;
        logic            d;
        logic [N*W-1:0]  vout;
        logic [W-1:0]    mn;
        logic [W-1:0]    mx;
        logic [W-1:0]    md;
        logic [N*IW-1:0] idx;
    } case_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;
    int outs  = 0;

    // Reference: each element's output position is its stable rank.
    function automatic exp_t model(input logic [N*W-1:0] v, input logic d);
        exp_t r;
        logic [W-1:0] e [N];
        int rk, ark;
        r = '0;
        for (int j = 0; j < N; j++) e[j] = v[j*W +: W];
        r.mn = e[0];
        r.mx = e[0];
        for (int j = 0; j < N; j++) begin
            if (e[j] < r.mn) r.mn = e[j];
            if (e[j] > r.mx) r.mx = e[j];
            rk  = 0;
            ark = 0;
            for (int k = 0; k < N; k++) begin
                if (k != j) begin
                    if ((d ? (e[k] > e[j]) : (e[k] < e[j])) || (e[k] == e[j] && k < j)) rk++;
                    if ((e[k] < e[j]) || (e[k] == e[j] && k < j)) ark++;
                end
            end
            r.data[rk*W +: W]   = e[j];
            r.idx[rk*IW +: IW]  = IW'(j);
            if (ark == (N - 1) / 2) r.md = e[j];
        end
        return r;
    endfunction

    // scoreboard monitor, samples 2 time units after the falling edge
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                outs++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_extra: got unexpected output data=%h", bus.out_data);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.out_data, bus.out_min, bus.out_max, bus.out_med} !==
                        {mon_e.data, mon_e.mn, mon_e.mx, mon_e.md}) begin
                        bad++;
                        $display("FAIL scoreboard: got data=%h min=%0d max=%0d med=%0d, want data=%h min=%0d max=%0d med=%0d",
                                 bus.out_data, bus.out_min, bus.out_max, bus.out_med,
                                 mon_e.data, mon_e.mn, mon_e.mx, mon_e.md);
                    end
`ifdef SORT_NET_IDX_EN
                    total++;
                    if (bus.out_idx !== mon_e.idx) begin
                        bad++;
                        $display("FAIL scoreboard_idx: got %h want %h", bus.out_idx, mon_e.idx);
                    end
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_data, bus.in_desc));
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom);
            bus.in_desc   = 1'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom);
            #1;
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
            end
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
            end
            total++;
            if ({bus.out_data, bus.out_min, bus.out_max, bus.out_med} !== '0) begin
                bad++; $display("FAIL reset_outputs: got data=%h min=%0d max=%0d med=%0d want all 0",
                                bus.out_data, bus.out_min, bus.out_max, bus.out_med);
            end
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_desc   = 1'b0;
        bus.in_data   = {8'd7, 8'd7, 8'd200, 8'd3};
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
        end
        // sample after edges t..t+4; valid must rise only after t+4
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            total++;
            if (bus.out_valid !== 1'(k == 4)) begin
                bad++; $display("FAIL latency_edge_t+%0d: got out_valid=%b want %b", k, bus.out_valid, (k == 4));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sort;
        case_t cs [4];
        logic found;
        cs[0] = '{vin: {8'd7, 8'd7, 8'd200, 8'd3}, d: 1'b0, vout: {8'd200, 8'd7, 8'd7, 8'd3},
                  mn: 8'd3, mx: 8'd200, md: 8'd7, idx: {2'd1, 2'd3, 2'd2, 2'd0}};
        cs[1] = '{vin: {8'd7, 8'd7, 8'd200, 8'd3}, d: 1'b1, vout: {8'd3, 8'd7, 8'd7, 8'd200},
                  mn: 8'd3, mx: 8'd200, md: 8'd7, idx: {2'd0, 2'd3, 2'd2, 2'd1}};
        cs[2] = '{vin: {8'd9, 8'd1, 8'd5, 8'd5}, d: 1'b0, vout: {8'd9, 8'd5, 8'd5, 8'd1},
                  mn: 8'd1, mx: 8'd9, md: 8'd5, idx: {2'd3, 2'd1, 2'd0, 2'd2}};
        cs[3] = '{vin: {8'd9, 8'd1, 8'd5, 8'd5}, d: 1'b1, vout: {8'd1, 8'd5, 8'd5, 8'd9},
                  mn: 8'd1, mx: 8'd9, md: 8'd5, idx: {2'd2, 2'd1, 2'd0, 2'd3}};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_desc   = cs[c].d;
            bus.in_data   = cs[c].vin;
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                #1;
                if (bus.out_valid) found = 1'b1;
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL sort_case%0d_timeout: got no out_valid want out_valid=1", c);
            end else if ({bus.out_data, bus.out_min, bus.out_max, bus.out_med} !==
                         {cs[c].vout, cs[c].mn, cs[c].mx, cs[c].md}) begin
                bad++;
                $display("FAIL sort_case%0d: got data=%h min=%0d max=%0d med=%0d, want data=%h min=%0d max=%0d med=%0d",
                         c, bus.out_data, bus.out_min, bus.out_max, bus.out_med,
                         cs[c].vout, cs[c].mn, cs[c].mx, cs[c].md);
            end
`ifdef SORT_NET_IDX_EN
            total++;
            if (bus.out_idx !== cs[c].idx) begin
                bad++; $display("FAIL sort_case%0d_idx: got %h want %h", c, bus.out_idx, cs[c].idx);
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int first, last, cnt, o0;
        first = -1; last = -1; cnt = 0; o0 = outs;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (k < 8) begin
                bus.in_valid = 1'b1;
                bus.in_desc  = 1'($urandom);
                bus.in_data  = (k == 0) ? {8'd255, 8'd0, 8'd255, 8'd0} : $urandom;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (k < 8) begin
                total++;
                if (bus.in_ready !== 1'b1) begin
                    bad++; $display("FAIL stream_in_ready_%0d: got %b want 1", k, bus.in_ready);
                end
            end
            if (bus.out_valid) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        total++;
        if (cnt != 8 || (last - first + 1) != 8) begin
            bad++; $display("FAIL stream_run: got %0d valid cycles spanning %0d want 8 consecutive", cnt, last - first + 1);
        end
        total++;
        if (outs - o0 != 8) begin
            bad++; $display("FAIL stream_count: got %0d outputs want 8", outs - o0);
        end
    endtask

    task automatic test_backpressure;
        logic [N*W-1:0] v [6];
        logic [N*W-1:0] held;
        int sent, stall_left, o0;
        for (int k = 0; k < 6; k++) v[k] = $urandom;
        sent = 0; stall_left = -1; o0 = outs; held = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall_left < 0 && bus.out_valid) stall_left = 3;
            bus.out_ready = !(stall_left > 0);
            if (sent < 6) begin
                bus.in_valid = 1'b1;
                bus.in_data  = v[sent];
                bus.in_desc  = 1'(sent % 2);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                total++;
                if (bus.in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_in_ready_stalled: got %b want 0", bus.in_ready);
                end
                if (stall_left == 3) held = bus.out_data;
                else begin
                    total++;
                    if (bus.out_data !== held) begin
                        bad++; $display("FAIL bp_hold: got %h want %h", bus.out_data, held);
                    end
                end
                stall_left--;
            end else begin
                total++;
                if (bus.in_ready !== 1'b1) begin
                    bad++; $display("FAIL bp_in_ready_free: cycle %0d got %b want 1", c, bus.in_ready);
                end
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        total++;
        if (outs - o0 != 6 || stall_left != 0) begin
            bad++; $display("FAIL bp_count: got %0d outputs (stall state %0d) want 6 (0)", outs - o0, stall_left);
        end
    endtask

    task automatic test_reset_midstream;
        logic seen;
        int o0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_desc  = 1'($urandom);
            bus.in_data  = $urandom;
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL midrst_fill: got out_valid=0 want 1 before reset");
        end
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            bad++; $display("FAIL midrst_drop: got out_valid=%b data=%h want 0 and 0", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        o0 = outs;
        repeat (10) @(negedge clk);
        #3;
        total++;
        if (outs != o0) begin
            bad++; $display("FAIL midrst_ghost: got %0d outputs after release want 0", outs - o0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_desc   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset;
        test_sort;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL leftover: got %0d pending vectors want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sort_net_pipe.md
# sort_net_pipe

Parametrised, fully pipelined N-input sorting network for unsigned samples. Accepts one N-element vector per clock through a valid/ready handshake. Returns the vector sorted ascending or descending, selectable per vector, plus its min, max and lower median. It is the general sorting core used by the median-filter datapath in place of fixed 4-input min/max trees.

## Interface
- `WIDTH`, 8: bits per unsigned element.
- `N`, 4: elements per vector; any integer 2..16.
- `IDXW`, `$clog2(N)`: index width, derived; not overridden.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input vector present.
- `in_ready` out 1: core can accept this cycle.
- `in_desc` in 1: 0 = ascending, 1 = descending; travels with the vector.
- `in_data` in N*WIDTH: element i at `[i*WIDTH +: WIDTH]`.
- `out_valid` out 1: sorted vector present.
- `out_ready` in 1: downstream accepts.
- `out_data` out N*WIDTH: sorted vector, same packing.
- `out_min`, `out_max`, `out_med` out WIDTH each: true min, true max, lower median.
- `out_idx` out N*IDXW: original index of each output element. Present only with `SORT_NET_IDX_EN`.

## Operation
- N registered stages, s = 0..N-1 (odd-even transposition). Stage s compare-swaps pairs (i, i+1), with i even for even s and i odd for odd s. Unpaired edge elements pass straight through.
- Compare rule, ascending: swap only if lower-position element > upper. Descending: swap only if lower < upper. Equal values never swap, so the sort is stable in both modes.
- Each stage register holds data, `desc` flag, valid bit and, if enabled, index tags.
- Index tags are initialised to i at stage 0 and swapped together with their data.
- `out_min`/`out_max` are taken from the final stage at position 0 or N-1, chosen by mode. They are always the numeric min and max.
- `out_med` is the element of ascending rank (N-1)/2 (floor). In descending mode this is position N-1-(N-1)/2.
- Backpressure: `stall = out_valid & ~out_ready`. While stalled, every stage register, valid bit included, holds its value, and `in_ready` = 0. Otherwise the whole pipeline advances one stage per cycle and `in_ready` = 1.
- `in_ready` depends on `out_valid` and `out_ready` only, never on `in_valid`.
- A vector is accepted when `in_valid & in_ready`. When `in_valid` = 0 while advancing, a bubble (valid = 0) enters.
- No arithmetic widening: comparisons are WIDTH-bit unsigned.

## Timing
- Reset (`rst` low, asynchronous): all valid bits 0, all data, flag and index registers 0. Consequently `out_valid` = 0, `out_data`/`out_min`/`out_max`/`out_med`/`out_idx` = 0, and `in_ready` = 1.
- Asserting reset mid-stream discards all in-flight vectors. First acceptance is possible on the first rising edge after release.
- Latency: a vector accepted at edge t appears with `out_valid` = 1 after edge t+N, absent stalls.
- Each stall cycle adds exactly one cycle of latency to every in-flight vector.
- Throughput: one vector per cycle when `out_ready` is held at 1.
- Outputs are driven directly from the final stage registers, so no combinational path runs from `in_*` to `out_*`.
- Simultaneous `in_valid` and stall: the vector is not accepted, and the source must hold it.
- Output data is stable while `out_valid & ~out_ready`.

## Configuration
- `SORT_NET_IDX_EN` defined: index tag registers and the `out_idx` port are present.
- Not defined: no tag registers and no `out_idx` port.
- Data, latency and handshake behaviour are identical in both builds.

## Test plan
All scenarios use N=4, WIDTH=8, and list in_data as elements 0..3.
- Reset: hold `rst` low with random inputs → `out_valid` = 0, all outputs 0, `in_ready` = 1. Release, accept {3,200,7,7} ascending at edge t → `out_valid` rises after edge t+4.
- Ascending: {3,200,7,7} → out {3,7,7,200}, min 3, max 200, med 7. Descending: same vector → out {200,7,7,3}, min 3, max 200, med 7.
- Stability (`SORT_NET_IDX_EN`): {5,5,1,9} ascending → out {1,5,5,9}, idx {2,0,1,3}. Descending → out {9,5,5,1}, idx {3,0,1,2}.
- Streaming: 8 back-to-back vectors with `out_ready` = 1 → 8 consecutive `out_valid` cycles, in order, each correctly sorted.
- Backpressure: stream 6 vectors and drop `out_ready` for 3 cycles while the first is on the output → `in_ready` = 0 for exactly those 3 cycles, output held stable, no vector lost or duplicated.
- Reset mid-stream: assert `rst` with 3 vectors in flight → `out_valid` drops immediately. None of the 3 ever appears after release.
